// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour BCD real-time clock with NUM_ALARMS alarm slots,
// snooze, ring timeout and a 12/24-hour display. A prescaler produces a
// one-cycle second tick, so everything runs in the single clk domain.
module multi_alarm_clock #(
    parameter int CLK_DIV    = 10,
    parameter int NUM_ALARMS = 4,
    parameter int AW         = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [2:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [AW-1:0]         AL_sel,
    input  logic [NUM_ALARMS-1:0] AL_en,
    input  logic                  STOP_al,
    input  logic                  SNOOZE,
    input  logic                  MODE_12h,
    output logic                  Alarm,
    output logic [AW-1:0]         Alarm_id,
    output logic                  Ld_err,
    output logic                  Tick_1s,
    output logic                  PM,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [2:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [2:0]            S_out1,
    output logic [3:0]            S_out0
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int RW = $clog2(RING_SEC + 1);
    localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RING    = 2'd1;
    localparam logic [1:0] ST_SNOOZED = 2'd2;

    // Hours and minutes as BCD digits; shared by the time and the alarm slots.
    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    logic [PW-1:0] pre_cnt;
    hhmm_t         hm;
    logic [2:0]    s1;
    logic [3:0]    s0;
    hhmm_t         nxt_hm;
    logic [2:0]    nxt_s1;
    logic [3:0]    nxt_s0;
    hhmm_t         in_hhmm;
    hhmm_t         slot [NUM_ALARMS];
    logic [1:0]    state;
    logic [AW-1:0] alarm_id;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snooze_cnt;
    logic          ld_err_q;
    logic          tick;
    logic          in_valid;
    logic          sel_ok;
    logic          time_load;
    logic          alarm_load;
    logic          minute_roll;
    logic          match_hit;
    logic [AW-1:0] match_idx;
    logic          ring_cancel;

    assign in_hhmm  = {H_in1, H_in0, M_in1, M_in0};
    assign tick     = (pre_cnt == PW'(CLK_DIV - 1));
    assign in_valid = ((H_in1 < 2'd2 && H_in0 <= 4'd9) || (H_in1 == 2'd2 && H_in0 <= 4'd3))
                      && (M_in1 <= 3'd5) && (M_in0 <= 4'd9);
    assign sel_ok     = ({1'b0, AL_sel} < (AW + 1)'(NUM_ALARMS));
    assign time_load  = LD_time & in_valid;
    assign alarm_load = LD_alarm & in_valid & sel_ok;
    // A tick out of xx:xx:59 lands on hh:mm:00, the only moment alarms are compared.
    assign minute_roll = tick & (s1 == 3'd5) & (s0 == 4'd9) & ~time_load;
    assign ring_cancel = STOP_al | ~AL_en[alarm_id];

    // Successor of the current time, one second later, as BCD with carries.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        nxt_hm = hm;
        nxt_s1 = s1;
        nxt_s0 = s0;
        if (s0 != 4'd9) begin
            nxt_s0 = s0 + 4'd1;
        end else begin
            nxt_s0 = 4'd0;
            if (s1 != 3'd5) begin
                nxt_s1 = s1 + 3'd1;
            end else begin
                nxt_s1 = 3'd0;
                if (hm.m0 != 4'd9) begin
                    nxt_hm.m0 = hm.m0 + 4'd1;
                end else begin
                    nxt_hm.m0 = 4'd0;
                    if (hm.m1 != 3'd5) begin
                        nxt_hm.m1 = hm.m1 + 3'd1;
                    end else begin
                        nxt_hm.m1 = 3'd0;
                        if (hm.h1 == 2'd2 && hm.h0 == 4'd3) begin
                            nxt_hm.h1 = 2'd0;
                            nxt_hm.h0 = 4'd0;
                        end else if (hm.h0 == 4'd9) begin
                            nxt_hm.h1 = hm.h1 + 2'd1;
                            nxt_hm.h0 = 4'd0;
                        end else begin
                            nxt_hm.h0 = hm.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Prescaler and time registers; a valid time load overrides a coincident tick.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            pre_cnt <= '0;
            hm      <= '0;
            s1      <= '0;
            s0      <= '0;
        end else if (time_load) begin
            pre_cnt <= '0;
            hm      <= in_hhmm;
            s1      <= '0;
            s0      <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                hm <= nxt_hm;
                s1 <= nxt_s1;
                s0 <= nxt_s0;
            end
        end
    end

    // Alarm slot storage, written by LD_alarm.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: this small register file is reset because slots must read 00:00 after reset; large RAMs normally are not.
        if (!reset_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) slot[i] <= '0;
        end else if (alarm_load) begin
            slot[AL_sel] <= in_hhmm;
        end
    end

    // Lowest enabled slot matching the time the current tick is about to show.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (minute_roll && AL_en[i] && slot[i] == nxt_hm) begin
                match_hit = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

    // Alarm state machine: stop and disable beat snooze, snooze beats the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            alarm_id   <= '0;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match_hit) begin
                        state    <= ST_RING;
                        alarm_id <= match_idx;
                        ring_cnt <= RW'(RING_SEC);
                    end
                end
                ST_RING: begin
                    if (ring_cancel) begin
                        state <= ST_IDLE;
                    end else if (SNOOZE) begin
                        state      <= ST_SNOOZED;
                        snooze_cnt <= SW'(SNOOZE_MIN * 60);
                    end else if (tick) begin
                        if (ring_cnt <= RW'(1)) state <= ST_IDLE;
                        else                    ring_cnt <= ring_cnt - RW'(1);
                    end
                end
                ST_SNOOZED: begin
                    if (ring_cancel) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        if (snooze_cnt <= SW'(1)) begin
                            state    <= ST_RING;
                            ring_cnt <= RW'(RING_SEC);
                        end else begin
                            snooze_cnt <= snooze_cnt - SW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered rejection pulse for malformed time or alarm loads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ld_err_q <= 1'b0;
        else          ld_err_q <= (LD_time & ~in_valid) | (LD_alarm & ~(in_valid & sel_ok));
    end

    // 12-hour display mapping of the hour digits; minutes and seconds pass through.
    always_comb begin
        H_out1 = hm.h1;
        H_out0 = hm.h0;
        if (MODE_12h) begin
            if (hm.h1 == 2'd0 && hm.h0 == 4'd0) begin
                H_out1 = 2'd1;
                H_out0 = 4'd2;
            end else if (hm.h1 == 2'd1 && hm.h0 >= 4'd3) begin
                H_out1 = 2'd0;
                H_out0 = hm.h0 - 4'd2;
            end else if (hm.h1 == 2'd2 && hm.h0 <= 4'd1) begin
                H_out1 = 2'd0;
                H_out0 = hm.h0 + 4'd8;
            end else if (hm.h1 == 2'd2) begin
                H_out1 = 2'd1;
                H_out0 = hm.h0 - 4'd2;
            end
        end
    end

    assign M_out1   = hm.m1;
    assign M_out0   = hm.m0;
    assign S_out1   = s1;
    assign S_out0   = s0;
    assign PM       = (hm.h1 == 2'd2) || (hm.h1 == 2'd1 && hm.h0 >= 4'd2);
    assign Alarm    = (state == ST_RING);
    assign Alarm_id = alarm_id;
    assign Ld_err   = ld_err_q;
    assign Tick_1s  = tick;

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised 24-hour BCD real-time clock with NUM_ALARMS independently enabled alarm slots, snooze, ring timeout and a 12/24-hour display mode. It is the next generation of the team's single-alarm clock block and sits between the user-input debouncers and the seven-segment display driver. It replaces the derived 1 s clock with a clock-enable prescaler, so the whole block runs on one clock domain.

## Interface
Parameters:
- CLK_DIV, default 10: number of clk cycles per second. Must be ≥ 2.
- NUM_ALARMS, default 4: number of alarm slots. Range 1..16.
- AW, default 2: alarm index width. Set to max(1, clog2(NUM_ALARMS)).
- SNOOZE_MIN, default 5: snooze length in minutes. Range 1..59.
- RING_SEC, default 60: ring auto-off timeout in seconds. Range 1..255.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- H_in1  in  2  hour tens digit, BCD 0-2.
- H_in0  in  4  hour ones digit, BCD 0-9.
- M_in1  in  3  minute tens digit, BCD 0-5.
- M_in0  in  4  minute ones digit, BCD 0-9.
- LD_time  in  1  load the current time from the H_in*/M_in* inputs.
- LD_alarm  in  1  load alarm slot AL_sel from the H_in*/M_in* inputs.
- AL_sel  in  AW  alarm slot index for LD_alarm.
- AL_en  in  NUM_ALARMS  per-slot alarm enable.
- STOP_al  in  1  stop the active alarm.
- SNOOZE  in  1  snooze the ringing alarm.
- MODE_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- Alarm  out  1  alarm ringing.
- Alarm_id  out  AW  index of the slot that triggered the current ring or snooze.
- Ld_err  out  1  one-cycle pulse when a load is rejected.
- Tick_1s  out  1  one-cycle pulse once per second.
- PM  out  1  1 when the internal hour is ≥ 12, independent of MODE_12h.
- H_out1  out  2  displayed hour tens digit.
- H_out0  out  4  displayed hour ones digit.
- M_out1  out  3  displayed minute tens digit.
- M_out0  out  4  displayed minute ones digit.
- S_out1  out  3  displayed second tens digit.
- S_out0  out  4  displayed second ones digit.

## Operation
- **Prescaler**
  - Counter runs 0..CLK_DIV-1.
  - Tick_1s = 1 in the cycle where the count equals CLK_DIV-1; the counter then wraps to 0.
- **Timekeeping**
  - Time is held directly as 24-hour BCD digit registers.
  - On a tick, seconds increment. 59 s wraps to 00 and carries into minutes; 59 min wraps to 00 and carries into hours.
  - 23:59:59 wraps to 00:00:00.
- **LD_time**
  - Validity check: hour ≤ 23, M_in1 ≤ 5, and ones digits ≤ 9.
  - Valid: load hh:mm, set seconds to 00, clear the prescaler. LD_time has priority over a coincident tick.
  - Invalid: time is unchanged and Ld_err pulses.
- **LD_alarm**
  - Same validity check as LD_time.
  - Valid: writes slot AL_sel. Invalid, or AL_sel ≥ NUM_ALARMS: Ld_err pulses and no slot is written.
  - LD_time and LD_alarm together: both act, each on the same inputs.
- **Match**
  - Evaluated only on a tick that advances the time to hh:mm:00.
  - Compares the new hh:mm against every slot i with AL_en[i] = 1.
  - The lowest matching index wins.
  - An LD_time that lands on an alarm time does not match.
- **Alarm FSM**, states IDLE, RINGING, SNOOZED:
  - IDLE → RINGING on a match. Alarm_id latches the winning index and the ring counter loads RING_SEC.
  - RINGING:
    - STOP_al → IDLE.
    - SNOOZE (with STOP_al low) → SNOOZED, snooze counter loads SNOOZE_MIN×60.
    - Ring counter reaches 0 → IDLE (auto-off).
    - Ring counter decrements on each tick.
  - SNOOZED:
    - Snooze counter decrements on each tick; at 0 → RINGING, ring counter reloads.
    - STOP_al → IDLE.
  - In RINGING or SNOOZED:
    - AL_en[Alarm_id] = 0 → IDLE.
    - New matches are ignored.
  - STOP_al has priority over SNOOZE.
  - Alarm = 1 only in RINGING.
- **Display** (combinational from the registers)
  - MODE_12h = 0: 24-hour digits.
  - MODE_12h = 1: hour 0 → 12, hours 13..23 → 1..11, others unchanged. Minutes and seconds are unchanged.

## Timing
- **Reset values:**
  - Outputs: Alarm 0, Alarm_id 0, Ld_err 0, Tick_1s 0, PM 0, time outputs read 00:00:00 (12:00:00 when MODE_12h = 1).
  - Internal state: prescaler 0, all alarm slots 00:00, FSM IDLE.
- **Tick cadence:** the first Tick_1s occurs CLK_DIV cycles after reset_n deasserts, then every CLK_DIV cycles.
- **Time update:** time registers update on the edge that ends the tick cycle.
- **Alarm assertion:** on a match, Alarm rises on that same edge, so the new time and Alarm are visible together.
- **Alarm deassertion:** STOP_al, SNOOZE and AL_en changes take effect on the next edge, so Alarm falls one cycle after the input is sampled.
- **Loads:** LD_time and LD_alarm take effect on the next edge. Ld_err is registered and high for exactly one cycle.
- **Level-sensitive loads:** a load held high reloads every cycle. Time stays frozen at hh:mm:00 and the prescaler stays at 0.
- **Reset mid-operation:** reset_n low at any point forces all reset values asynchronously.

## Test plan
Bench uses CLK_DIV = 4 and NUM_ALARMS = 4.

1. **Reset and tick cadence:** release reset → Tick_1s on cycles 4, 8, 12, and S_out0 reads 1, 2, 3.
2. **Full-day wrap:** LD_time 23:59, then 60 ticks → outputs read 00:00:00 with PM 0. In MODE_12h = 1, H_out reads 12.
3. **Two-slot priority:** load slot 2 and slot 1 both with 07:30, AL_en = 4'b0110, LD_time 07:29 → after 60 ticks Alarm = 1 and Alarm_id = 1.
4. **Snooze then auto-off:** with SNOOZE_MIN = 1 and RING_SEC = 3, pulse SNOOZE while ringing → Alarm = 0 for 60 ticks, then 1 for 3 ticks, then 0 in IDLE.
5. **Stop priority and disable:**
   - STOP_al and SNOOZE in the same cycle → IDLE.
   - Clearing AL_en[Alarm_id] while ringing → Alarm = 0 on the next edge.
6. **Invalid loads:**
   - LD_time with H_in = 2,4 → Ld_err pulses for one cycle and time is unchanged.
   - LD_alarm with M_in1 = 6 → Ld_err pulses and no slot is written.
   - Reset pulsed mid-ring → Alarm = 0 immediately.
